fifo_sync_param: RTL and testbench

Parametrised synchronous FIFO, next generation of the 8x8 FIFO in the fifo test environment. Generalised width, depth and occupancy thresholds. Adds a count output, almost-full/almost-empty flags, and sticky overflow/underflow error flags with a synchronous clear. Sits between a producer and a consumer in one clock domain; port names and semantics stay compatible with the existing fifo_property checker.

---
 rtl/fifo_sync_param.sv | 163 ++++++++++++++++
 tb/tb_fifo_sync_param.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// ---------------------------------------------------------------------------
// fifo_sync_param
// Parametrised single-clock FIFO with occupancy count, almost-full /
// almost-empty flags and sticky overflow / underflow error flags.
//
// Parameters
//   FIFO_WIDTH    : data width in bits (>= 1)
//   FIFO_DEPTH    : number of entries, power of two (>= 2)
//   AFULL_THRESH  : fifo_afull when count >= AFULL_THRESH  (1..FIFO_DEPTH)
//   AEMPTY_THRESH : fifo_aempty when count <= AEMPTY_THRESH (0..FIFO_DEPTH-1)
//
// Ports
//   clk            in   rising-edge clock
//   rst_           in   asynchronous active-low reset
//   fifo_write     in   write request
//   fifo_read      in   read request
//   fifo_data_in   in   write data [FIFO_WIDTH]
//   err_clr        in   synchronous clear of the sticky error flags
//   fifo_data_out  out  registered read data [FIFO_WIDTH]
//   fifo_full      out  count == FIFO_DEPTH
//   fifo_empty     out  count == 0
//   fifo_afull     out  count >= AFULL_THRESH
//   fifo_aempty    out  count <= AEMPTY_THRESH
//   fifo_count     out  current occupancy [$clog2(FIFO_DEPTH)+1]
//   fifo_overflow  out  sticky: a write was rejected
//   fifo_underflow out  sticky: a read was rejected
//
// All status outputs are decodes of the registered occupancy counter only,
// so there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module fifo_sync_param #(
   parameter int FIFO_WIDTH    = 8,
   parameter int FIFO_DEPTH    = 8,
   parameter int AFULL_THRESH  = 6,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                          clk,
   input  logic                          rst_,
   input  logic                          fifo_write,
   input  logic                          fifo_read,
   input  logic [FIFO_WIDTH-1:0]         fifo_data_in,
   input  logic                          err_clr,
   output logic [FIFO_WIDTH-1:0]         fifo_data_out,
   output logic                          fifo_full,
   output logic                          fifo_empty,
   output logic                          fifo_afull,
   output logic                          fifo_aempty,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          fifo_overflow,
   output logic                          fifo_underflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] C_DEPTH  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] C_AFULL  = CW'(AFULL_THRESH);
   localparam logic [CW-1:0] C_AEMPTY = CW'(AEMPTY_THRESH);
   localparam logic [CW-1:0] C_CNT_1  = CW'(1'b1);
   localparam logic [AW-1:0] C_PTR_1  = AW'(1'b1);

   // Storage and state
   logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_cnt;
   logic [FIFO_WIDTH-1:0] r_data_out;
   logic                  r_overflow;
   logic                  r_underflow;

   // Combinational decode
   logic                  w_full;
   logic                  w_empty;
   logic                  w_rd_ok;
   logic                  w_wr_ok;
   logic                  w_ovf_set;
   logic                  w_unf_set;
   logic [CW-1:0]         w_cnt_nxt;
   logic                  w_ovf_nxt;
   logic                  w_unf_nxt;

   assign w_full  = (r_cnt == C_DEPTH);
   assign w_empty = (r_cnt == {CW{1'b0}});

   // A read is only accepted when data is present. A write into a full FIFO
   // is still accepted when a read frees a slot on the same edge.
   assign w_rd_ok = fifo_read && !w_empty;
   assign w_wr_ok = fifo_write && (!w_full || fifo_read);

   assign w_ovf_set = fifo_write && w_full && !fifo_read;
   assign w_unf_set = fifo_read && w_empty;

   // Next occupancy: simultaneous accepted read and write leave it unchanged
   always_comb begin
      w_cnt_nxt = r_cnt;
      case ({w_wr_ok, w_rd_ok})
         2'b10:   w_cnt_nxt = r_cnt + C_CNT_1;
         2'b01:   w_cnt_nxt = r_cnt - C_CNT_1;
         default: w_cnt_nxt = r_cnt;
      endcase
   end

   // Sticky error flags: a new error wins over a clear in the same cycle
   always_comb begin
      w_ovf_nxt = r_overflow;
      w_unf_nxt = r_underflow;
      if (w_ovf_set) begin
         w_ovf_nxt = 1'b1;
      end else if (err_clr) begin
         w_ovf_nxt = 1'b0;
      end else begin
         w_ovf_nxt = r_overflow;
      end
      if (w_unf_set) begin
         w_unf_nxt = 1'b1;
      end else if (err_clr) begin
         w_unf_nxt = 1'b0;
      end else begin
         w_unf_nxt = r_underflow;
      end
   end

   // Storage write port; the array is deliberately left out of reset
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[r_wr_ptr] <= fifo_data_in;
      end
   end

   // Pointers, occupancy, read data register and error flags
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_wr_ptr    <= {AW{1'b0}};
         r_rd_ptr    <= {AW{1'b0}};
         r_cnt       <= {CW{1'b0}};
         r_data_out  <= {FIFO_WIDTH{1'b0}};
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         // Pointers wrap naturally because FIFO_DEPTH == 2**AW
         if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_1;
         end
         if (w_rd_ok) begin
            r_rd_ptr   <= r_rd_ptr + C_PTR_1;
            r_data_out <= r_mem[r_rd_ptr];
         end
         r_cnt       <= w_cnt_nxt;
         r_overflow  <= w_ovf_nxt;
         r_underflow <= w_unf_nxt;
      end
   end

   assign fifo_data_out  = r_data_out;
   assign fifo_count     = r_cnt;
   assign fifo_full      = w_full;
   assign fifo_empty     = w_empty;
   assign fifo_afull     = (r_cnt >= C_AFULL);
   assign fifo_aempty    = (r_cnt <= C_AEMPTY);
   assign fifo_overflow  = r_overflow;
   assign fifo_underflow = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_param
// Two FIFO instances (8x8 with thresholds 6/2, 16x12 with thresholds 13/3)
// are compared every cycle against queue-based reference models. Directed
// scenarios on the 8x8 instance carry hand-written literal expectations;
// a randomized phase then exercises both instances, including pointer wrap.
// ---------------------------------------------------------------------------
module tb_fifo_sync_param;

   logic clk;
   logic rst_;

   // 8x8 instance signals
   logic        w8, r8, c8;
   logic [7:0]  d8;
   logic [7:0]  dout8;
   logic        full8, empty8, afull8, aempty8, ovf8, unf8;
   logic [3:0]  cnt8;

   // 16x12 instance signals
   logic        w16, r16, c16;
   logic [11:0] d16;
   logic [11:0] dout16;
   logic        full16, empty16, afull16, aempty16, ovf16, unf16;
   logic [4:0]  cnt16;

   int n_checks;
   int n_fail;
   bit chk_en;

   // Reference models: contents as queues plus a few scalars
   logic [7:0]  m8_q[$];
   logic [7:0]  m8_dout;
   bit          m8_ovf, m8_unf;
   int          m8_wr, m8_rd;
   logic [11:0] m16_q[$];
   logic [11:0] m16_dout;
   bit          m16_ovf, m16_unf;
   int          m16_wr, m16_rd;

   fifo_sync_param #(
      .FIFO_WIDTH(8), .FIFO_DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2)
   ) u_d8 (
      .clk(clk), .rst_(rst_),
      .fifo_write(w8), .fifo_read(r8), .fifo_data_in(d8), .err_clr(c8),
      .fifo_data_out(dout8), .fifo_full(full8), .fifo_empty(empty8),
      .fifo_afull(afull8), .fifo_aempty(aempty8), .fifo_count(cnt8),
      .fifo_overflow(ovf8), .fifo_underflow(unf8)
   );

   fifo_sync_param #(
      .FIFO_WIDTH(12), .FIFO_DEPTH(16), .AFULL_THRESH(13), .AEMPTY_THRESH(3)
   ) u_d16 (
      .clk(clk), .rst_(rst_),
      .fifo_write(w16), .fifo_read(r16), .fifo_data_in(d16), .err_clr(c16),
      .fifo_data_out(dout16), .fifo_full(full16), .fifo_empty(empty16),
      .fifo_afull(afull16), .fifo_aempty(aempty16), .fifo_count(cnt16),
      .fifo_overflow(ovf16), .fifo_underflow(unf16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m8_q.delete();
      m8_dout = 8'h00; m8_ovf = 1'b0; m8_unf = 1'b0; m8_wr = 0; m8_rd = 0;
      m16_q.delete();
      m16_dout = 12'h000; m16_ovf = 1'b0; m16_unf = 1'b0; m16_wr = 0; m16_rd = 0;
   endtask

   // One clock of both models, using the inputs present at the edge
   task automatic model_step();
      bit full, empty, rok, wok, ovs, uns;
      full  = (m8_q.size() == 8);
      empty = (m8_q.size() == 0);
      rok = r8 && !empty;
      wok = w8 && (!full || r8);
      ovs = w8 && full && !r8;
      uns = r8 && empty;
      if (rok) begin m8_dout = m8_q.pop_front(); m8_rd++; end
      if (wok) begin m8_q.push_back(d8); m8_wr++; end
      m8_ovf = ovs ? 1'b1 : (c8 ? 1'b0 : m8_ovf);
      m8_unf = uns ? 1'b1 : (c8 ? 1'b0 : m8_unf);

      full  = (m16_q.size() == 16);
      empty = (m16_q.size() == 0);
      rok = r16 && !empty;
      wok = w16 && (!full || r16);
      ovs = w16 && full && !r16;
      uns = r16 && empty;
      if (rok) begin m16_dout = m16_q.pop_front(); m16_rd++; end
      if (wok) begin m16_q.push_back(d16); m16_wr++; end
      m16_ovf = ovs ? 1'b1 : (c16 ? 1'b0 : m16_ovf);
      m16_unf = uns ? 1'b1 : (c16 ? 1'b0 : m16_unf);
   endtask

   // Advance one clock; stimulus code runs at posedge+1
   task automatic tick();
      @(posedge clk);
      #1;
      if (rst_) model_step();
      else      model_reset();
   endtask

   // Cycle-by-cycle comparison against the models on the falling edge
   always @(negedge clk) begin
      if (chk_en) begin
         chk("d8_count",  cnt8,    m8_q.size());
         chk("d8_full",   full8,   m8_q.size() == 8);
         chk("d8_empty",  empty8,  m8_q.size() == 0);
         chk("d8_afull",  afull8,  m8_q.size() >= 6);
         chk("d8_aempty", aempty8, m8_q.size() <= 2);
         chk("d8_dout",   dout8,   m8_dout);
         chk("d8_ovf",    ovf8,    m8_ovf);
         chk("d8_unf",    unf8,    m8_unf);
         chk("d8_wrptr",  u_d8.r_wr_ptr, m8_wr % 8);
         chk("d8_rdptr",  u_d8.r_rd_ptr, m8_rd % 8);
         chk("d16_count",  cnt16,    m16_q.size());
         chk("d16_full",   full16,   m16_q.size() == 16);
         chk("d16_empty",  empty16,  m16_q.size() == 0);
         chk("d16_afull",  afull16,  m16_q.size() >= 13);
         chk("d16_aempty", aempty16, m16_q.size() <= 3);
         chk("d16_dout",   dout16,   m16_dout);
         chk("d16_ovf",    ovf16,    m16_ovf);
         chk("d16_unf",    unf16,    m16_unf);
         chk("d16_wrptr",  u_d16.r_wr_ptr, m16_wr % 16);
         chk("d16_rdptr",  u_d16.r_rd_ptr, m16_rd % 16);
      end
   end

   int ph;
   logic [7:0] exp_byte;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      chk_en   = 1'b0;
      rst_ = 1'b0;
      w8 = 1'b0; r8 = 1'b0; c8 = 1'b0; d8 = 8'h00;
      w16 = 1'b0; r16 = 1'b0; c16 = 1'b0; d16 = 12'h000;
      model_reset();
      tick();
      chk_en = 1'b1;
      tick();
      rst_ = 1'b1;

      // Power-on reset values
      chk("por_count", cnt8, 0);
      chk("por_empty", empty8, 1);
      chk("por_aempty", aempty8, 1);
      chk("por_dout", dout8, 0);

      // Reset mid-stream: 6 writes, 1 read -> count 5, dout 0x01
      for (int i = 1; i <= 6; i++) begin
         w8 = 1'b1; d8 = 8'(i);
         tick();
      end
      w8 = 1'b0; r8 = 1'b1;
      tick();
      r8 = 1'b0;
      chk("mid_count", cnt8, 5);
      chk("mid_dout", dout8, 8'h01);
      rst_ = 1'b0;
      model_reset();
      #2;
      chk("rst_count", cnt8, 0);
      chk("rst_empty", empty8, 1);
      chk("rst_full", full8, 0);
      chk("rst_aempty", aempty8, 1);
      chk("rst_afull", afull8, 0);
      chk("rst_dout", dout8, 0);
      chk("rst_ovf", ovf8, 0);
      chk("rst_unf", unf8, 0);
      tick();
      tick();
      rst_ = 1'b1;

      // Fill with 0x11..0x88
      for (int i = 1; i <= 8; i++) begin
         w8 = 1'b1; d8 = 8'(i * 17);
         tick();
         chk("fill_count", cnt8, i);
         chk("fill_afull", afull8, (i >= 6) ? 1 : 0);
         chk("fill_full", full8, (i == 8) ? 1 : 0);
      end

      // Overflow: write while full without read
      w8 = 1'b1; r8 = 1'b0; d8 = 8'h99;
      tick();
      chk("ovf_count", cnt8, 8);
      chk("ovf_flag", ovf8, 1);
      chk("ovf_wrptr", u_d8.r_wr_ptr, 0);
      w8 = 1'b0; c8 = 1'b1;
      tick();
      c8 = 1'b0;
      chk("ovf_clr", ovf8, 0);

      // Full with simultaneous read and write
      w8 = 1'b1; r8 = 1'b1; d8 = 8'h5A;
      tick();
      chk("frw_count", cnt8, 8);
      chk("frw_dout", dout8, 8'h11);
      chk("frw_ovf", ovf8, 0);

      // Drain: 0x22..0x88 then 0x5A
      w8 = 1'b0; r8 = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         exp_byte = (k < 8) ? 8'((k + 1) * 17) : 8'h5A;
         chk("drain_dout", dout8, exp_byte);
         chk("drain_count", cnt8, 8 - k);
         chk("drain_aempty", aempty8, (k >= 6) ? 1 : 0);
         chk("drain_empty", empty8, (k == 8) ? 1 : 0);
      end
      r8 = 1'b0;

      // Underflow with simultaneous write into an empty FIFO
      w8 = 1'b1; r8 = 1'b1; d8 = 8'hA5;
      tick();
      chk("unf_count", cnt8, 1);
      chk("unf_flag", unf8, 1);
      chk("unf_dout", dout8, 8'h5A);
      w8 = 1'b0; r8 = 1'b1;
      tick();
      chk("unf_read", dout8, 8'hA5);
      // Set and clear in the same cycle: set wins
      r8 = 1'b1; c8 = 1'b1;
      tick();
      chk("unf_setwins", unf8, 1);
      r8 = 1'b0; c8 = 1'b1;
      tick();
      chk("unf_clr", unf8, 0);
      c8 = 1'b0;

      // Randomized phase on both instances, alternating write- and read-heavy
      for (int i = 0; i < 480; i++) begin
         ph  = (i / 30) % 2;
         w8  = ($urandom_range(99) < ((ph == 0) ? 75 : 30));
         r8  = ($urandom_range(99) < ((ph == 0) ? 30 : 75));
         d8  = 8'($urandom);
         c8  = ($urandom_range(15) == 0);
         w16 = ($urandom_range(99) < ((ph == 0) ? 80 : 35));
         r16 = ($urandom_range(99) < ((ph == 0) ? 35 : 80));
         d16 = 12'($urandom);
         c16 = ($urandom_range(15) == 0);
         tick();
      end
      w8 = 1'b0; r8 = 1'b0; c8 = 1'b0;
      w16 = 1'b0; r16 = 1'b0; c16 = 1'b0;
      tick();
      chk_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
